// File: rtl/ppm16_rx_byte_fifo.sv
// rtl/ppm16_rx_byte_fifo.sv - PPM16 symbol-pair packer with SOF-tagged show-ahead byte FIFO
module ppm16_rx_byte_fifo #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [3:0]           sym_in,
    input  logic                 sym_valid,
    input  logic                 packet_start,
    input  logic                 flush,
    input  logic                 clear_overflow,
    input  logic                 rd_ready,
    output logic                 rd_valid,
    output logic [7:0]           rd_data,
    output logic                 rd_sof,
    output logic [ADDR_BITS:0]   level,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_LVL = (ADDR_BITS + 1)'(DEPTH);

    logic [8:0]           mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count;
    logic                 nib_pending;
    logic [3:0]           hi_nib;
    logic                 sof_pending;

    logic nib_now;
    logic wr_req;
    logic wr_acc;
    logic wr_drop;
    logic rd_acc;
    logic [8:0] wr_entry;

    assign level    = count;
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_LVL);
    assign rd_valid = ~empty;
    assign rd_acc   = rd_valid & rd_ready;

    // packet_start wins over a held nibble, so a same-cycle symbol starts a fresh byte
    assign nib_now  = nib_pending & ~packet_start;
    assign wr_req   = sym_valid & nib_now;
    assign wr_acc   = wr_req & (~full | rd_acc);
    assign wr_drop  = wr_req & ~wr_acc & ~flush;
    assign wr_entry = {sof_pending, hi_nib, sym_in};

    assign rd_data  = empty ? 8'h00 : mem[rd_ptr][7:0];
    assign rd_sof   = ~empty & mem[rd_ptr][8];

    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            nib_pending <= 1'b0;
            hi_nib      <= 4'h0;
            sof_pending <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (wr_drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end

            if (flush) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                nib_pending <= 1'b0;
                sof_pending <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (wr_acc && !rd_acc) begin
                    count <= count + 1'b1;
                end else if (rd_acc && !wr_acc) begin
                    count <= count - 1'b1;
                end

                // a dropped byte leaves SOF armed for the next accepted byte
                if (wr_acc) begin
                    sof_pending <= 1'b0;
                end else if (packet_start) begin
                    sof_pending <= 1'b1;
                end

                if (sym_valid) begin
                    if (nib_now) begin
                        nib_pending <= 1'b0;
                    end else begin
                        hi_nib      <= sym_in;
                        nib_pending <= 1'b1;
                    end
                end else if (packet_start) begin
                    nib_pending <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ppm16_rx_byte_fifo.sv
// tb/tb_ppm16_rx_byte_fifo.sv - self-checking bench for ppm16_rx_byte_fifo against a queue model
module tb_ppm16_rx_byte_fifo;
    localparam int AB    = 2;
    localparam int DEPTH = 1 << AB;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [3:0]    sym_in = 4'h0;
    logic          sym_valid = 1'b0;
    logic          packet_start = 1'b0;
    logic          flush = 1'b0;
    logic          clear_overflow = 1'b0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          rd_sof;
    logic [AB:0]   level;
    logic          full;
    logic          empty;
    logic          overflow;

    int ncmp = 0;
    int nfail = 0;

    ppm16_rx_byte_fifo #(.ADDR_BITS(AB)) dut (
        .clk(clk), .resetn(resetn), .sym_in(sym_in), .sym_valid(sym_valid),
        .packet_start(packet_start), .flush(flush), .clear_overflow(clear_overflow),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_sof(rd_sof),
        .level(level), .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {sof, byte} plus the packer's held nibble and flags
    logic [8:0] mq[$];
    logic       m_nib;
    logic [3:0] m_hi;
    logic       m_sof;
    logic       m_ovf;

    task automatic model_reset();
        mq.delete();
        m_nib = 0; m_hi = 0; m_sof = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        bit was_full, rd, wr;
        logic [7:0] b;
        if (flush) begin
            mq.delete();
            m_nib = 0; m_sof = 0;
            if (clear_overflow) m_ovf = 0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        rd = (mq.size() > 0) && rd_ready;
        wr = 0;
        b = 8'h00;
        if (packet_start) begin
            m_nib = 0; m_sof = 1;
        end
        if (sym_valid) begin
            if (m_nib) begin
                wr = 1; b = {m_hi, sym_in}; m_nib = 0;
            end else begin
                m_hi = sym_in; m_nib = 1;
            end
        end
        if (rd) void'(mq.pop_front());
        if (wr) begin
            if (!was_full || rd) begin
                mq.push_back({m_sof, b});
                m_sof = 0;
            end else begin
                m_ovf = 1;
            end
        end else if (clear_overflow) begin
            m_ovf = 0;
        end
        if (wr && (!was_full || rd) && clear_overflow) m_ovf = 0;
    endtask

    function automatic logic [15:0] model_vec();
        logic [8:0] h;
        int sz;
        sz = mq.size();
        h = (sz > 0) ? mq[0] : 9'h000;
        return {sz != 0, h[7:0], h[8], 3'(sz), sz == DEPTH, sz == 0, m_ovf};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {rd_valid, rd_data, rd_sof, level, full, empty, overflow};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        sym_valid = 0; packet_start = 0; flush = 0; clear_overflow = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ps);
        packet_start = ps; sym_valid = 1; sym_in = b[7:4];
        tick();
        sym_valid = 1; sym_in = b[3:0];
        tick();
    endtask

    task automatic test_reset();
        resetn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        ncmp++;
        if (dut_vec() !== {1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
            nfail++; $display("FAIL reset_state: got %h want %h", dut_vec(), {1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0});
        end
        resetn = 1;
        tick();
        ncmp++;
        if (dut_vec() !== model_vec()) begin
            nfail++; $display("FAIL reset_idle: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_basic();
        rd_ready = 0;
        packet_start = 1; tick();
        sym_valid = 1; sym_in = 4'hA; tick();
        ncmp++;
        if (rd_valid !== 1'b0) begin nfail++; $display("FAIL basic_half: rd_valid got %b want 0", rd_valid); end
        sym_valid = 1; sym_in = 4'h5; tick();
        ncmp++;
        if ({rd_valid, rd_data, rd_sof, level} !== {1'b1, 8'hA5, 1'b1, 3'd1}) begin
            nfail++; $display("FAIL basic_first: got %b/%h/%b/%0d want 1/a5/1/1", rd_valid, rd_data, rd_sof, level);
        end
        sym_valid = 1; sym_in = 4'h3; tick();
        sym_valid = 1; sym_in = 4'hC; tick();
        ncmp++;
        if (level !== 3'd2) begin nfail++; $display("FAIL basic_level: got %0d want 2", level); end
        rd_ready = 1; tick();
        ncmp++;
        if ({rd_data, rd_sof} !== {8'h3C, 1'b0}) begin
            nfail++; $display("FAIL basic_second: got %h/%b want 3c/0", rd_data, rd_sof);
        end
        tick();
        rd_ready = 0;
        ncmp++;
        if (empty !== 1'b1 || rd_data !== 8'h00) begin
            nfail++; $display("FAIL basic_drained: empty %b data %h want 1/00", empty, rd_data);
        end
    endtask

    task automatic test_partial();
        packet_start = 1; tick();
        sym_valid = 1; sym_in = 4'h7; tick();
        packet_start = 1; tick();
        send_byte(8'h12, 0);
        ncmp++;
        if ({level, rd_data, rd_sof} !== {3'd1, 8'h12, 1'b1}) begin
            nfail++; $display("FAIL partial_discard: got %0d/%h/%b want 1/12/1", level, rd_data, rd_sof);
        end
        ncmp++;
        if (dut_vec() !== model_vec()) begin nfail++; $display("FAIL partial_model: got %h want %h", dut_vec(), model_vec()); end
        flush = 1; tick();
    endtask

    task automatic test_overflow();
        logic [7:0] sent[5];
        rd_ready = 0;
        for (int i = 0; i < 5; i++) begin
            sent[i] = 8'($urandom);
            send_byte(sent[i], i == 0);
            if (i == 3) begin
                ncmp++;
                if (full !== 1'b1 || overflow !== 1'b0) begin
                    nfail++; $display("FAIL ovf_full: full %b ovf %b want 1/0", full, overflow);
                end
            end
        end
        ncmp++;
        if (overflow !== 1'b1 || level !== 3'd4) begin
            nfail++; $display("FAIL ovf_set: ovf %b level %0d want 1/4", overflow, level);
        end
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            ncmp++;
            if ({rd_data, rd_sof} !== {sent[i], i == 0}) begin
                nfail++; $display("FAIL ovf_drain%0d: got %h/%b want %h/%b", i, rd_data, rd_sof, sent[i], i == 0);
            end
            tick();
        end
        rd_ready = 0;
        ncmp++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            nfail++; $display("FAIL ovf_sticky: empty %b ovf %b want 1/1", empty, overflow);
        end
        clear_overflow = 1; tick();
        ncmp++;
        if (overflow !== 1'b0) begin nfail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        sym_valid = 1; sym_in = 4'h1; tick();
        sym_valid = 1; sym_in = 4'h2; clear_overflow = 1; tick();
        ncmp++;
        if (overflow !== 1'b1) begin nfail++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
        clear_overflow = 1; tick();
        ncmp++;
        if (dut_vec() !== model_vec()) begin nfail++; $display("FAIL ovf_model: got %h want %h", dut_vec(), model_vec()); end
        flush = 1; tick();
    endtask

    task automatic test_sof_drop();
        rd_ready = 0;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), i == 0);
        packet_start = 1; tick();
        send_byte(8'hEE, 0);
        ncmp++;
        if (overflow !== 1'b1 || level !== 3'd4) begin
            nfail++; $display("FAIL sofdrop_drop: ovf %b level %0d want 1/4", overflow, level);
        end
        rd_ready = 1; tick(); rd_ready = 0;
        send_byte(8'h44, 0);
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            ncmp++;
            if (dut_vec() !== model_vec()) begin nfail++; $display("FAIL sofdrop_model%0d: got %h want %h", i, dut_vec(), model_vec()); end
            if (i == 3) begin
                ncmp++;
                if ({rd_data, rd_sof} !== {8'h44, 1'b1}) begin
                    nfail++; $display("FAIL sofdrop_sof: got %h/%b want 44/1", rd_data, rd_sof);
                end
            end
            tick();
        end
        rd_ready = 0;
        clear_overflow = 1; tick();
    endtask

    task automatic test_pass_through();
        logic [7:0] sent[$];
        logic [7:0] got[$];
        logic [7:0] b;
        rd_ready = 0;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), i == 0);
        sym_valid = 1; sym_in = 4'h9; tick();
        rd_ready = 1; sym_valid = 1; sym_in = 4'h9; tick();
        rd_ready = 0;
        ncmp++;
        if (level !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
            nfail++; $display("FAIL pass_through: level %0d ovf %b full %b want 4/0/1", level, overflow, full);
        end
        flush = 1; tick();
        rd_ready = 1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            packet_start = (i == 0); sym_valid = 1; sym_in = b[7:4];
            if (rd_valid) got.push_back(rd_data);
            tick();
            sym_valid = 1; sym_in = b[3:0];
            if (rd_valid) got.push_back(rd_data);
            tick();
        end
        if (rd_valid) got.push_back(rd_data);
        tick();
        rd_ready = 0;
        ncmp++;
        if (got.size() != sent.size()) begin
            nfail++; $display("FAIL wrap_count: got %0d want %0d", got.size(), sent.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                ncmp++;
                if (got[i] !== sent[i]) begin nfail++; $display("FAIL wrap_order%0d: got %h want %h", i, got[i], sent[i]); end
            end
        end
    endtask

    task automatic test_flush();
        logic ovf_before;
        rd_ready = 0;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), i == 0);
        sym_valid = 1; sym_in = 4'hF; tick();
        ovf_before = overflow;
        flush = 1; sym_valid = 1; sym_in = 4'h3; tick();
        ncmp++;
        if ({empty, level, overflow} !== {1'b1, 3'd0, ovf_before}) begin
            nfail++; $display("FAIL flush_clear: empty %b level %0d ovf %b want 1/0/%b", empty, level, overflow, ovf_before);
        end
        send_byte(8'h5A, 0);
        ncmp++;
        if ({level, rd_data, rd_sof} !== {3'd1, 8'h5A, 1'b0}) begin
            nfail++; $display("FAIL flush_packer: got %0d/%h/%b want 1/5a/0", level, rd_data, rd_sof);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            sym_valid      = ($urandom_range(0, 9) < 7);
            sym_in         = 4'($urandom);
            packet_start   = ($urandom_range(0, 19) == 0);
            rd_ready       = ($urandom_range(0, 1) == 1);
            clear_overflow = ($urandom_range(0, 19) == 0);
            flush          = ($urandom_range(0, 99) == 0);
            tick();
            ncmp++;
            if (dut_vec() !== model_vec()) begin
                nfail++; $display("FAIL random_c%0d: got %h want %h", c, dut_vec(), model_vec());
            end
        end
        rd_ready = 0;
    endtask

    task automatic test_reset_mid();
        send_byte(8'hB7, 1);
        sym_valid = 1; sym_in = 4'h6;
        #2 resetn = 0;
        #1;
        model_reset();
        sym_valid = 0;
        ncmp++;
        if (dut_vec() !== {1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
            nfail++; $display("FAIL reset_mid: got %h want %h", dut_vec(), {1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0});
        end
        @(negedge clk);
        resetn = 1;
        sym_valid = 1; sym_in = 4'h2; tick();
        sym_valid = 1; sym_in = 4'h8; tick();
        ncmp++;
        if ({level, rd_data, rd_sof} !== {3'd1, 8'h28, 1'b0}) begin
            nfail++; $display("FAIL reset_mid_packer: got %0d/%h/%b want 1/28/0", level, rd_data, rd_sof);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_overflow();
        test_sof_drop();
        test_pass_through();
        test_flush();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/ppm16_rx_byte_fifo.md
# ppm16_rx_byte_fifo

Receive-side stage directly downstream of the 16-ary PPM demodulator. It takes the demodulator's 4-bit symbol stream (`dout`/`dout_valid`) and its start-of-data pulse (`packet_detected`), and packs symbol pairs into bytes. Each byte is tagged with a start-of-packet flag and buffered in a synchronous FIFO. Readout uses a show-ahead valid/ready interface for the scan-chain/SPI readout logic.

## Interface
- `ADDR_BITS`, 4 — FIFO address width; depth = 2**ADDR_BITS entries (min 1, i.e. depth 2).
- `clk`  in  1  clock; all logic rising-edge.
- `resetn`  in  1  reset: asynchronous, active-low.
- `sym_in`  in  4  demodulated symbol (demod `dout`).
- `sym_valid`  in  1  `sym_in` valid this cycle (demod `dout_valid`).
- `packet_start`  in  1  single-cycle pulse at start of data field (demod `packet_detected`).
- `flush`  in  1  synchronous clear of FIFO and packer.
- `clear_overflow`  in  1  synchronous clear of sticky `overflow`.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_valid`  out  1  head entry available (= ~`empty`).
- `rd_data`  out  8  head byte; 8'h00 while `empty`.
- `rd_sof`  out  1  head byte is the first byte of a packet; 0 while `empty`.
- `level`  out  ADDR_BITS+1  number of stored entries, 0..DEPTH.
- `full`  out  1  `level` == DEPTH.
- `empty`  out  1  `level` == 0.
- `overflow`  out  1  sticky: a completed byte was dropped because the FIFO was full.

## Operation
- **Packer state:**
  - `nib_pending` (1b): a high nibble is held.
  - `hi_nib` (4b): the held high nibble.
  - `sof_pending` (1b): the next written byte is the first byte of a packet.
- **packet_start:**
  - Clears `nib_pending`; any partial byte from the previous packet is discarded.
  - Sets `sof_pending`.
- **sym_valid with `nib_pending`=0:** `hi_nib` <= `sym_in`; `nib_pending` <= 1.
- **sym_valid with `nib_pending`=1:**
  - Forms byte {`hi_nib`, `sym_in`}; the first symbol is the MSB nibble.
  - Issues a write of {`sof_pending`, byte}; `nib_pending` <= 0.
- **Same-cycle `packet_start` and `sym_valid`:** `packet_start` is applied first. `sym_in` becomes the high nibble of the new packet's first byte, and `sof_pending` stays 1.
- **Write accept:** write is accepted if `full`=0, or if a read is accepted in the same cycle (pass-through at full).
  - On acceptance: the entry is stored at `wr_ptr`, `wr_ptr` increments, and `sof_pending` <= 0.
- **Write drop:** a write that is not accepted:
  - drops the byte and sets `overflow`;
  - leaves `sof_pending` unchanged, so the next accepted byte carries SOF.
- **Read accept:** a read is accepted when `rd_valid` && `rd_ready`; `rd_ptr` increments.
- **Pointers:** ADDR_BITS wide and wrap modulo DEPTH.
  - `level` increments on write-only, decrements on read-only, and is unchanged on simultaneous read+write.
- **Head outputs:** `rd_data`/`rd_sof` are driven combinationally from `mem[rd_ptr]`, gated to 0 when empty. FIFO memory is not reset.
- **flush:**
  - Next cycle: both pointers = 0, `level` = 0, `nib_pending` = 0, `sof_pending` = 0.
  - Overrides any same-cycle write/read and any same-cycle `packet_start`.
  - Does not clear `overflow`.
- **overflow:** cleared by `clear_overflow`. A set in the same cycle as `clear_overflow` wins (stays 1).

## Timing
- **Reset values:** `rd_valid`=0, `rd_data`=8'h00, `rd_sof`=0, `level`=0, `full`=0, `empty`=1, `overflow`=0. Internally, pointers=0, `nib_pending`=0, `sof_pending`=0.
- **Resetn mid-packet:** immediate return to reset values; held data is lost.
- **Latency:** a second-nibble `sym_valid` in cycle N gives the byte at the head with `rd_valid`=1 in cycle N+1 (FIFO previously empty).
- **Read throughput:** one read per cycle. `rd_valid` deasserts the cycle after the last entry is read, unless a write lands in the same cycle.
- **Empty + same-cycle write:** no read occurs, since `rd_valid` is 0. The data appears in N+1.
- **Full + same-cycle read and write:** both accepted; `level` stays DEPTH, `overflow` is not set.
- **`sym_valid` spacing:** no minimum required; back-to-back `sym_valid` on every cycle is supported.

## Test plan
- **Basic packet:** reset; `packet_start`; then symbols 0xA,0x5,0x3,0xC on consecutive cycles -> two entries, (8'hA5, sof=1) then (8'h3C, sof=0). `rd_valid` rises the cycle after 0x5; `level` reaches 2.
- **Partial byte discard:** `packet_start`, symbol 0x7, `packet_start`, symbols 0x1,0x2 -> single entry 8'h12 with sof=1; 0x7 never appears.
- **Overflow:** ADDR_BITS=2, `rd_ready`=0, push 5 bytes -> `full`=1 after 4 and `overflow`=1 after the 5th. Draining yields the first 4 bytes in order, `overflow` stays 1 until `clear_overflow`, and a simultaneous set+clear leaves it 1.
- **SOF preserved across drop:** FIFO full; `packet_start`; byte 8'hEE dropped; one read; next byte 8'h44 -> 8'h44 stored with sof=1.
- **Pass-through at full and wrap:** with `rd_ready`=1 and `full`=1, write 8'h99 while reading -> `level` stays DEPTH and no overflow. Streaming 3×DEPTH bytes gives in-order output across pointer wrap.
- **Flush/reset mid-operation:** with `level`=3, a pending nibble, and `flush` asserted together with `sym_valid` -> next cycle `empty`=1, `level`=0, no write, `overflow` unchanged. Asserting `resetn`=0 mid-stream immediately gives all reset values.
